// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV flag bit positions
// for the conditional-execute unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'ha,
    LT = 4'hb,
    GT = 4'hc,
    LE = 4'hd,
    AL = 4'he,
    NV = 4'hf
  } cond_e;

  localparam int unsigned FN = 3;
  localparam int unsigned FZ = 2;
  localparam int unsigned FC = 1;
  localparam int unsigned FV = 0;

endpackage

// File: rtl/cond_exec_unit_eval.sv
// Combinational evaluator: one 4-bit condition code against
// one set of {N,Z,C,V} flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FN];
  assign z = flags[FZ];
  assign c = flags[FC];
  assign v = flags[FV];

  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Multi-lane conditional-execute unit: NZCV status register,
// per-lane condition evaluation, execute enables, squash counter.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int REG_OUT   = 1,
  parameter int BYPASS    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sr_we,
  input  logic [3:0]             sr_din,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   cnt_clr,
  input  logic [NUM_LANES-1:0]   in_valid,
  input  logic [4*NUM_LANES-1:0] in_cond,
  output logic [NUM_LANES-1:0]   out_valid,
  output logic [NUM_LANES-1:0]   out_exec,
  output logic [3:0]             status,
  output logic [CNT_W-1:0]       squash_cnt
);

  localparam int IW = CNT_W + 3;
  localparam logic [IW-1:0] CMAX = {3'b000, {CNT_W{1'b1}}};

  logic [3:0]           flags;
  logic [NUM_LANES-1:0] pass;
  logic [NUM_LANES-1:0] accepted;
  logic [NUM_LANES-1:0] squashed;
  logic [IW-1:0]        inc;
  logic [IW-1:0]        sum;

  assign flags = ((BYPASS != 0) && sr_we) ? sr_din : status;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cond_eval u_eval (
      .cond  (in_cond[4*i +: 4]),
      .flags (flags),
      .pass  (pass[i])
    );
  end

  assign accepted = in_valid & {NUM_LANES{~stall & ~flush}};
  assign squashed = accepted & ~pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= 4'b0000;
    end else if (sr_we) begin
      status <= sr_din;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= '0;
        out_exec  <= '0;
      end else if (flush) begin
        out_valid <= '0;
        out_exec  <= '0;
      end else if (!stall) begin
        out_valid <= in_valid;
        out_exec  <= in_valid & pass;
      end
    end
  end else begin : g_comb
    assign out_valid = in_valid & {NUM_LANES{~flush}};
    assign out_exec  = out_valid & pass;
  end

  // widened sum so count+inc can be compared against the ceiling
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      inc = inc + IW'(squashed[i]);
    end
    sum = IW'(squash_cnt) + inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_cnt <= '0;
    end else if (cnt_clr) begin
      squash_cnt <= '0;
    end else if (sum > CMAX) begin
      squash_cnt <= {CNT_W{1'b1}};
    end else begin
      squash_cnt <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit: three configurations share
// one stimulus stream and are checked against hand-derived values.
module tb_cond_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       sr_we;
  logic [3:0] sr_din;
  logic       stall;
  logic       flush;
  logic       cnt_clr;
  logic [1:0] in_valid;
  logic [7:0] in_cond;

  logic [1:0]  ov_a, oe_a, ov_b, oe_b, ov_c, oe_c;
  logic [3:0]  st_a, st_b, st_c;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A: registered, no bypass, 16-bit counter
  cond_exec_unit #(.NUM_LANES(2), .REG_OUT(1), .BYPASS(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .sr_we(sr_we), .sr_din(sr_din),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_a), .out_exec(oe_a), .status(st_a),
    .squash_cnt(cnt_a)
  );

  // B: registered, bypass, 4-bit counter
  cond_exec_unit #(.NUM_LANES(2), .REG_OUT(1), .BYPASS(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .sr_we(sr_we), .sr_din(sr_din),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_b), .out_exec(oe_b), .status(st_b),
    .squash_cnt(cnt_b)
  );

  // C: combinational outputs, bypass
  cond_exec_unit #(.NUM_LANES(2), .REG_OUT(0), .BYPASS(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .sr_we(sr_we), .sr_din(sr_din),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_cond(in_cond),
    .out_valid(ov_c), .out_exec(oe_c), .status(st_c),
    .squash_cnt(cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sr_we = 0; sr_din = 0; stall = 0; flush = 0;
    cnt_clr = 0; in_valid = 0; in_cond = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #3;
    rst = 0;
  endtask

  task automatic set_sr(input logic [3:0] f);
    sr_we = 1; sr_din = f; in_valid = 0;
    step();
    sr_we = 0;
  endtask

  // even code selects a base test, odd code inverts it
  function automatic logic ref_pass(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = ~(n ^ v);
      3'd6: b = ~z & ~(n ^ v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  initial begin
    idle();
    rst = 0;
    @(negedge clk);
    do_reset();
    chk("rst_status", st_a, 4'h0);
    chk("rst_valid", ov_a, 2'b00);
    chk("rst_exec", oe_a, 2'b00);
    chk("rst_cnt", cnt_a, 16'd0);

    // full flag x code table on lane 0 of A
    for (int f = 0; f < 16; f++) begin
      set_sr(4'(f));
      for (int c = 0; c < 16; c++) begin
        in_valid = 2'b01;
        in_cond = {4'he, 4'(c)};
        step();
        chk($sformatf("tbl f=%h c=%h", f, c), oe_a[0],
            ref_pass(4'(c), 4'(f)));
      end
    end
    in_valid = 0;
    set_sr(4'b0010);
    in_valid = 2'b01; in_cond = 8'he9;
    step();
    chk("ls_c1z0", oe_a, 2'b00);
    set_sr(4'b1001);
    in_valid = 2'b01; in_cond = 8'hec;
    step();
    chk("gt_n1v1", oe_a, 2'b01);
    in_cond = 8'hef;
    step();
    chk("nv", oe_a, 2'b00);

    // bypass vs registered status
    do_reset();
    sr_we = 1; sr_din = 4'b0100;
    in_valid = 2'b01; in_cond = 8'h00;
    #1;
    chk("c_byp_exec", oe_c, 2'b01);
    flush = 1;
    #1;
    chk("c_flush_valid", ov_c, 2'b00);
    flush = 0;
    step();
    chk("b_byp_exec", oe_b, 2'b01);
    chk("a_nobyp_exec", oe_a, 2'b00);
    chk("a_status_new", st_a, 4'b0100);
    sr_we = 0;
    step();
    chk("a_repeat_exec", oe_a, 2'b01);

    // stall holds, flush wins over stall
    do_reset();
    set_sr(4'b0100);
    in_valid = 2'b11; in_cond = 8'h10;
    step();
    chk("ld_valid", ov_a, 2'b11);
    chk("ld_exec", oe_a, 2'b01);
    chk("ld_cnt", cnt_a, 16'd1);
    stall = 1; in_valid = 2'b10; in_cond = 8'hee;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_valid", k), ov_a, 2'b11);
      chk($sformatf("stall%0d_exec", k), oe_a, 2'b01);
      chk($sformatf("stall%0d_cnt", k), cnt_a, 16'd1);
    end
    flush = 1; in_valid = 2'b11; in_cond = 8'h11;
    step();
    chk("flush_valid", ov_a, 2'b00);
    chk("flush_exec", oe_a, 2'b00);
    chk("flush_cnt", cnt_a, 16'd1);

    // two squashes per cycle, invalid lanes ignored, clear wins
    do_reset();
    in_valid = 2'b11; in_cond = 8'h00;
    for (int k = 0; k < 5; k++) step();
    chk("cnt10", cnt_a, 16'd10);
    in_valid = 2'b00; in_cond = 8'hff;
    step();
    chk("inv_cnt", cnt_a, 16'd10);
    chk("inv_exec", oe_a, 2'b00);
    in_valid = 2'b11; in_cond = 8'h00; cnt_clr = 1;
    step();
    chk("clr_cnt", cnt_a, 16'd0);
    chk("clr_valid", ov_a, 2'b11);
    cnt_clr = 0;

    // saturation on the 4-bit counter
    do_reset();
    in_valid = 2'b11; in_cond = 8'h00;
    for (int k = 0; k < 7; k++) step();
    chk("b_cnt14", cnt_b, 4'd14);
    step();
    chk("b_cnt15", cnt_b, 4'd15);
    step();
    step();
    chk("b_sat", cnt_b, 4'd15);
    chk("a_cnt20", cnt_a, 16'd20);

    // async reset mid-cycle
    do_reset();
    set_sr(4'b1111);
    in_valid = 2'b11; in_cond = 8'hfe;
    step();
    chk("pre_valid", ov_a, 2'b11);
    chk("pre_cnt", cnt_a, 16'd1);
    #2;
    rst = 1;
    #1;
    chk("ar_status", st_a, 4'h0);
    chk("ar_valid", ov_a, 2'b00);
    chk("ar_exec", oe_a, 2'b00);
    chk("ar_cnt", cnt_a, 16'd0);
    rst = 0;
    in_valid = 2'b11; in_cond = 8'h01;
    step();
    chk("post_exec", oe_a, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
